// File: rtl/riscv_regfile_sb.sv
// riscv_regfile_sb: register file with a per-register busy (scoreboard) bit.
// Two combinational read ports, one write port, and a registered count of busy registers.
// Index 0 is hard-wired to zero and is never busy.
// Optional macro REGFILE_BYPASS_EN: a same-cycle writeback to the index being read is
// forwarded to that read port, and the operand is reported ready.
module riscv_regfile_sb #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] reg_data_rs1,
    output logic [XLEN-1:0] reg_data_rs2,
    output logic            rs1_ready,
    output logic            rs2_ready,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    input  logic            reg_write_en,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] data_to_reg,
    input  logic            flush,
    output logic [AW:0]     pend_cnt
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     pend_q, pend_d;

    function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            c = c + (AW+1)'(v[i]);
        end
        return c;
    endfunction

    // Next busy vector: flush wins; otherwise clear on writeback, then set on issue so a
    // new producer to the same index supersedes the completing one.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (reg_write_en) busy_d[rd] = 1'b0;
            if (issue_en) busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
        pend_d    = popcount(busy_d);
    end

    // Register array: writes to index 0 are dropped; writeback still happens during flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_write_en && (rd != '0)) begin
            regs_q[rd] <= data_to_reg;
        end
    end

    // Scoreboard state and its registered popcount.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

    // Read port 1: zero for index 0, optional write-through forwarding.
    always_comb begin
        reg_data_rs1 = (rs1 == '0) ? '0 : regs_q[rs1];
        rs1_ready    = (rs1 == '0) || !busy_q[rs1];
`ifdef REGFILE_BYPASS_EN
        if (reg_write_en && (rd == rs1) && (rs1 != '0)) begin
            reg_data_rs1 = data_to_reg;
            rs1_ready    = 1'b1;
        end
`endif
    end

    // Read port 2: same behaviour as port 1.
    always_comb begin
        reg_data_rs2 = (rs2 == '0) ? '0 : regs_q[rs2];
        rs2_ready    = (rs2 == '0) || !busy_q[rs2];
`ifdef REGFILE_BYPASS_EN
        if (reg_write_en && (rd == rs2) && (rs2 != '0)) begin
            reg_data_rs2 = data_to_reg;
            rs2_ready    = 1'b1;
        end
`endif
    end

    assign pend_cnt = pend_q;

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Testbench for riscv_regfile_sb: directed vector table, hand-written multi-cycle
// sequences (writeback/ready, async reset), then randomized traffic against a model.
module tb_riscv_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   rs1, rs2, issue_rd, rd;
    logic [XLEN-1:0] reg_data_rs1, reg_data_rs2, data_to_reg;
    logic            rs1_ready, rs2_ready, issue_en, reg_write_en, flush;
    logic [AW:0]     pend_cnt;

    int checks = 0;
    int errors = 0;

    riscv_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rs1          (rs1),
        .rs2          (rs2),
        .reg_data_rs1 (reg_data_rs1),
        .reg_data_rs2 (reg_data_rs2),
        .rs1_ready    (rs1_ready),
        .rs2_ready    (rs2_ready),
        .issue_en     (issue_en),
        .issue_rd     (issue_rd),
        .reg_write_en (reg_write_en),
        .rd           (rd),
        .data_to_reg  (data_to_reg),
        .flush        (flush),
        .pend_cnt     (pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        issue_en = 1'b0; issue_rd = '0; reg_write_en = 1'b0; rd = '0;
        data_to_reg = '0; flush = 1'b0;
    endtask

    // Directed vectors: inputs applied in the low clock phase, outputs checked before the
    // following rising edge (so they reflect state from earlier rows).
    typedef struct {
        logic        iss;
        logic [4:0]  ird;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] data;
        logic        fl;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        r1;
        logic        r2;
        logic [5:0]  ep;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    function automatic vec_t mkv(input int iss, input int ird, input int we, input int wrd,
                                 input logic [31:0] data, input int fl, input int a1,
                                 input int a2, input logic [31:0] e1, input logic [31:0] e2,
                                 input int r1, input int r2, input int ep);
        vec_t v;
        v.iss = iss[0]; v.ird = 5'(ird); v.we = we[0]; v.wrd = 5'(wrd); v.data = data;
        v.fl = fl[0]; v.a1 = 5'(a1); v.a2 = 5'(a2); v.e1 = e1; v.e2 = e2;
        v.r1 = r1[0]; v.r2 = r2[0]; v.ep = 6'(ep);
        return v;
    endfunction

    // Reference model: architectural contents, set of busy registers.
    logic [31:0] m_mem  [NREG];
    bit          m_busy [NREG];

    function automatic logic [31:0] m_read(input int idx);
`ifdef REGFILE_BYPASS_EN
        if (idx != 0 && reg_write_en && int'(rd) == idx) return data_to_reg;
`endif
        return (idx == 0) ? 32'h0 : m_mem[idx];
    endfunction

    function automatic logic m_ready(input int idx);
        if (idx == 0) return 1'b1;
`ifdef REGFILE_BYPASS_EN
        if (reg_write_en && int'(rd) == idx) return 1'b1;
`endif
        return !m_busy[idx];
    endfunction

    function automatic int m_pend();
        int n = 0;
        foreach (m_busy[i]) if (m_busy[i]) n++;
        return n;
    endfunction

    // Apply the rules of one clock edge to the model.
    task automatic m_edge();
        if (reg_write_en && rd != 0) m_mem[rd] = data_to_reg;
        if (flush) begin
            foreach (m_busy[i]) m_busy[i] = 0;
        end else begin
            if (reg_write_en) m_busy[rd] = 0;
            if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1;
        end
    endtask

    initial begin
        idle();
        rs1 = '0; rs2 = '0;

        // Reset: everything reads as zero / ready.
        repeat (2) @(negedge clk);
        #1 chk("in_reset pend", 32'(pend_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            @(negedge clk);
            rs1 = AW'(i); rs2 = AW'(NREG - 1 - i);
            #1;
            chk($sformatf("reset rd1 x%0d", i), reg_data_rs1, 0);
            chk($sformatf("reset rd2 x%0d", NREG - 1 - i), reg_data_rs2, 0);
            chk($sformatf("reset rdy1 x%0d", i), 32'(rs1_ready), 1);
            chk($sformatf("reset rdy2 x%0d", NREG - 1 - i), 32'(rs2_ready), 1);
        end
        chk("reset pend", 32'(pend_cnt), 0);

        //            iss ird we rd data          fl a1 a2  e1            e2 r1 r2 ep
        tbl[0]  = mkv(0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 32'h0,        0, 1, 1, 0);
        tbl[1]  = mkv(0, 0, 0, 0, 32'h0,        0, 0, 3, 32'h0,        0, 1, 1, 0);
        tbl[2]  = mkv(1, 7, 0, 0, 32'h0,        0, 1, 2, 32'h0,        0, 1, 1, 0);
        tbl[3]  = mkv(1, 7, 1, 7, 32'h77,       0, 1, 2, 32'h0,        0, 1, 1, 1);
        tbl[4]  = mkv(0, 0, 0, 0, 32'h0,        0, 7, 0, 32'h77,       0, 0, 1, 1);
        tbl[5]  = mkv(1, 1, 0, 0, 32'h0,        0, 7, 1, 32'h77,       0, 0, 1, 1);
        tbl[6]  = mkv(1, 2, 0, 0, 32'h0,        0, 1, 2, 32'h0,        0, 0, 1, 2);
        tbl[7]  = mkv(1, 3, 0, 0, 32'h0,        0, 2, 3, 32'h0,        0, 0, 1, 3);
        tbl[8]  = mkv(1, 4, 0, 0, 32'h0,        1, 3, 4, 32'h0,        0, 0, 1, 4);
        tbl[9]  = mkv(0, 0, 0, 0, 32'h0,        0, 1, 4, 32'h0,        0, 1, 1, 0);
        tbl[10] = mkv(0, 0, 0, 0, 32'h0,        0, 7, 3, 32'h77,       0, 1, 1, 0);
        tbl[11] = mkv(0, 0, 1, 7, 32'h1234,     0, 9, 0, 32'h0,        0, 1, 1, 0);
        tbl[12] = mkv(0, 0, 0, 0, 32'h0,        0, 7, 0, 32'h1234,     0, 1, 1, 0);
        tbl[13] = mkv(1, 5, 0, 0, 32'h0,        0, 5, 0, 32'h0,        0, 1, 1, 0);
        tbl[14] = mkv(1, 5, 0, 0, 32'h0,        0, 5, 6, 32'h0,        0, 0, 1, 1);
        tbl[15] = mkv(0, 0, 0, 0, 32'h0,        0, 5, 6, 32'h0,        0, 0, 1, 1);
        tbl[16] = mkv(0, 0, 1, 5, 32'h55,       0, 1, 6, 32'h0,        0, 1, 1, 1);
        tbl[17] = mkv(0, 0, 0, 0, 32'h0,        0, 5, 0, 32'h55,       0, 1, 1, 0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            issue_en = tbl[i].iss; issue_rd = tbl[i].ird; reg_write_en = tbl[i].we;
            rd = tbl[i].wrd; data_to_reg = tbl[i].data; flush = tbl[i].fl;
            rs1 = tbl[i].a1; rs2 = tbl[i].a2;
            #1;
            chk($sformatf("vec%0d rd1", i), reg_data_rs1, tbl[i].e1);
            chk($sformatf("vec%0d rd2", i), reg_data_rs2, tbl[i].e2);
            chk($sformatf("vec%0d rdy1", i), 32'(rs1_ready), 32'(tbl[i].r1));
            chk($sformatf("vec%0d rdy2", i), 32'(rs2_ready), 32'(tbl[i].r2));
            chk($sformatf("vec%0d pend", i), 32'(pend_cnt), 32'(tbl[i].ep));
        end

        // Issue x5, then writeback x5 while reading it.
        @(negedge clk);
        idle(); issue_en = 1'b1; issue_rd = 5; rs1 = 0; rs2 = 0;
        @(negedge clk);
        idle(); rs1 = 5;
        #1;
        chk("seq35 busy rdy1", 32'(rs1_ready), 0);
        chk("seq35 busy pend", 32'(pend_cnt), 1);
        reg_write_en = 1'b1; rd = 5; data_to_reg = 32'h12345678;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("seq35 bypass rd1", reg_data_rs1, 32'h12345678);
        chk("seq35 bypass rdy1", 32'(rs1_ready), 1);
`else
        chk("seq35 nobypass rd1", reg_data_rs1, 32'h55);
        chk("seq35 nobypass rdy1", 32'(rs1_ready), 0);
`endif
        @(negedge clk);
        idle();
        #1;
        chk("seq35 after pend", 32'(pend_cnt), 0);
        chk("seq35 after rd1", reg_data_rs1, 32'h12345678);
        chk("seq35 after rdy1", 32'(rs1_ready), 1);

        // Asynchronous reset in the middle of a cycle clears state before any clock edge.
        @(negedge clk);
        reg_write_en = 1'b1; rd = 9; data_to_reg = 32'hA5A5A5A5; issue_en = 1'b1;
        issue_rd = 9; rs1 = 9; rs2 = 0;
        @(negedge clk);
        idle();
        #1;
        chk("async pre rd1", reg_data_rs1, 32'hA5A5A5A5);
        chk("async pre pend", 32'(pend_cnt), 1);
        #1 rst = 1'b1;
        #1;
        chk("async rd1", reg_data_rs1, 0);
        chk("async rdy1", 32'(rs1_ready), 1);
        chk("async pend", 32'(pend_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        // Reset raised while a write is presented: the write is lost.
        @(negedge clk);
        reg_write_en = 1'b1; rd = 9; data_to_reg = 32'hCAFEF00D;
        #2 rst = 1'b1;
        @(negedge clk);
        idle();
        rst = 1'b0;
        #1;
        chk("midwrite rd1", reg_data_rs1, 0);
        chk("midwrite rdy1", 32'(rs1_ready), 1);

        // Randomized traffic against the model, starting from the reset state.
        foreach (m_mem[i]) begin
            m_mem[i] = '0;
            m_busy[i] = 0;
        end
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            issue_en     = ($urandom % 3) != 0;
            issue_rd     = AW'($urandom_range(0, 7));
            reg_write_en = ($urandom % 2) != 0;
            rd           = AW'($urandom_range(0, 7));
            data_to_reg  = $urandom;
            flush        = ($urandom % 16) == 0;
            rs1          = AW'($urandom_range(0, 7));
            rs2          = AW'($urandom % NREG);
            #1;
            chk($sformatf("rnd%0d rd1", n), reg_data_rs1, m_read(int'(rs1)));
            chk($sformatf("rnd%0d rd2", n), reg_data_rs2, m_read(int'(rs2)));
            chk($sformatf("rnd%0d rdy1", n), 32'(rs1_ready), 32'(m_ready(int'(rs1))));
            chk($sformatf("rnd%0d rdy2", n), 32'(rs2_ready), 32'(m_ready(int'(rs2))));
            chk($sformatf("rnd%0d pend", n), 32'(pend_cnt), 32'(m_pend()));
            @(posedge clk);
            m_edge();
        end

        @(negedge clk);
        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_regfile_sb.md
RISCV_REGFILE_SB -- requirements
Module: riscv_regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width in bits.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers (power of two, at least 2).
REQ-003 SHALL have parameter AW, default 5, register index width, equal to log2(NREG).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port rs1, input, AW, read port 1 index.
REQ-007 SHALL have port rs2, input, AW, read port 2 index.
REQ-008 SHALL have port reg_data_rs1, output, XLEN, read port 1 data.
REQ-009 SHALL have port reg_data_rs2, output, XLEN, read port 2 data.
REQ-010 SHALL have port rs1_ready, output, 1, operand 1 has no pending writer.
REQ-011 SHALL have port rs2_ready, output, 1, operand 2 has no pending writer.
REQ-012 SHALL have port issue_en, input, 1, an instruction writing issue_rd issues this cycle.
REQ-013 SHALL have port issue_rd, input, AW, destination of the issuing instruction.
REQ-014 SHALL have port reg_write_en, input, 1, writeback valid.
REQ-015 SHALL have port rd, input, AW, writeback destination.
REQ-016 SHALL have port data_to_reg, input, XLEN, writeback data.
REQ-017 SHALL have port flush, input, 1, discard all pending writers.
REQ-018 SHALL have port pend_cnt, output, AW+1, number of registers currently marked busy.

Function
REQ-019 SHALL write data_to_reg into register[rd] on the rising clk edge when reg_write_en=1 and rd!=0.
REQ-020 SHALL ignore all writes to index 0; reads of index 0 SHALL return 0 and the ready outputs SHALL be 1 for index 0.
REQ-021 SHALL drive both read ports combinationally from the register array with zero latency.
REQ-022 SHALL keep one busy bit per register: set at the clk edge when issue_en=1 (issue_rd!=0), cleared at the clk edge when reg_write_en=1.
REQ-023 SHALL leave busy set on an issue and a writeback to the same index in the same cycle, because a new producer supersedes the old one; the data write SHALL still occur.
REQ-024 SHALL drive rsN_ready = !busy[rsN], or 1 when the bypass condition of REQ-031 holds.
REQ-025 SHALL, when flush=1, clear every busy bit at the clk edge with priority over issue_en, and SHALL still perform a same-cycle writeback data write.
REQ-026 SHALL keep pend_cnt equal to the popcount of the busy bits after every edge (+1 on set-only, -1 on clear-only, unchanged on set and clear of the same index, 0 after flush).
REQ-027 SHALL never let pend_cnt exceed NREG-1 or wrap below 0.
REQ-028 SHALL treat a writeback to a non-busy register as a data write only, leaving pend_cnt unchanged.

Reset
REQ-029 SHALL, while rst=1, immediately force all registers to 0, all busy bits to 0 and pend_cnt to 0, independent of clk.
REQ-030 SHALL, on reset release, drive reg_data_rs1=reg_data_rs2=0 and rs1_ready=rs2_ready=1; a reset asserted mid-write SHALL discard that write.

Configuration
REQ-031 SHALL, with macro REGFILE_BYPASS_EN defined, return data_to_reg on read port N when reg_write_en=1, rd==rsN and rsN!=0 (write-through in the same cycle), and SHALL treat that operand as ready.
REQ-032 SHALL, without REGFILE_BYPASS_EN, return only the stored array value, making a write visible from the cycle after the edge, and rsN_ready SHALL be !busy[rsN] only.

Verification
REQ-033 SHALL cover: reset, then read all indices -> all data 0, all ready 1, pend_cnt=0.
REQ-034 SHALL cover: write rd=0 with 0xDEADBEEF, then read rs1=0 -> 0x00000000.
REQ-035 SHALL cover: issue rd=5, next cycle rs1=5 -> rs1_ready=0 and pend_cnt=1; writeback rd=5 with 0x12345678 -> with bypass enabled, same cycle reg_data_rs1=0x12345678 and rs1_ready=1; next cycle pend_cnt=0.
REQ-036 SHALL cover: issue rd=7 and writeback rd=7 in the same cycle -> busy[7] stays 1, pend_cnt unchanged, register[7] updated.
REQ-037 SHALL cover: issue rd=1,2,3, then flush together with issue rd=4 -> pend_cnt=0 and all four operands ready.
REQ-038 SHALL cover: assert rst asynchronously mid-cycle after writing 0xA5A5A5A5 to x9 -> reg_data for x9 reads 0 immediately, before the next clk edge.
